// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter front end: FSM state encoding and
// a width-parameterised saturating increment.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned SAT_MAX_W = 64;

    // Increments val by one when inc is set, holding at the all-ones value of a width-bit word.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] val,
        input logic                 inc,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] max_val;
        max_val = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
        if (inc && (val < max_val)) begin
            return val + SAT_MAX_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/counter_bin_timer.sv
// Bin-length down-counter: loaded with max(length,1) at trigger, strobes
// o_bin_end in the last cycle of every bin and reloads with no dead cycles.
module counter_bin_timer
    import counter_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_run,
    input  logic [LEN_WIDTH-1:0] i_len,
    output logic                 o_bin_end
);

    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] len_eff;

    assign len_eff   = (i_len == '0) ? LEN_WIDTH'(1) : i_len;
    assign o_bin_end = i_run && (cnt_q == LEN_WIDTH'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_q <= LEN_WIDTH'(1);
            cnt_q <= LEN_WIDTH'(1);
        end else if (i_load) begin
            len_q <= len_eff;
            cnt_q <= len_eff;
        end else if (i_run) begin
            cnt_q <= o_bin_end ? len_q : (cnt_q - LEN_WIDTH'(1));
        end
    end

endmodule

// File: rtl/counter_bin_writer.sv
// Time-binning front end: counts event strobes per fixed-length bin and writes
// each finished bin into the counter SRAM through channel A.
module counter_bin_writer
    import counter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_trigger,
    input  logic                  i_continuous,
    input  logic [LEN_WIDTH-1:0]  i_bin_length,
    input  logic [ADDR_WIDTH:0]   i_num_bins,
    input  logic                  i_event,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_write_ptr,
    output logic                  o_saturated
);

    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

    state_e                state_q;
    logic                  cont_q;
    logic [ADDR_WIDTH:0]   num_bins_q;
    logic [ADDR_WIDTH:0]   wr_idx_q;
    logic [ADDR_WIDTH:0]   wr_next;
    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic [DATA_WIDTH-1:0] bin_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  sat_q;
    logic                  start;
    logic                  bin_end;
    logic                  sat_hit;
    logic                  last_bin;

    assign start    = (state_q == IDLE) && i_enable && i_trigger && (i_num_bins != '0);
    assign bin_cnt  = DATA_WIDTH'(sat_inc(SAT_MAX_W'(count_q), i_event, DATA_WIDTH));
    assign sat_hit  = i_event && (&count_q);
    assign wr_next  = wr_idx_q + IDX_ONE;
    assign last_bin = (wr_next == num_bins_q);

    // The counter restarts at zero after a bin end so an event in the next bin's first cycle lands there.
    always_comb begin
        count_d = bin_cnt;
        if (bin_end) begin
            count_d = '0;
        end
    end

    counter_bin_timer #(
        .LEN_WIDTH(LEN_WIDTH)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (start),
        .i_run    (state_q == RUN),
        .i_len    (i_bin_length),
        .o_bin_end(bin_end)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cont_q     <= 1'b0;
            num_bins_q <= '0;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (!i_enable) begin
                // Abort: the partial bin is dropped, including one ending this very cycle.
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            cont_q     <= i_continuous;
                            num_bins_q <= i_num_bins;
                            wr_idx_q   <= '0;
                            wr_ptr_q   <= '0;
                            count_q    <= '0;
                            sat_q      <= 1'b0;
                        end
                    end
                    RUN: begin
                        count_q <= count_d;
                        if (sat_hit) begin
                            sat_q <= 1'b1;
                        end
                        if (bin_end) begin
                            we_q     <= 1'b1;
                            addr_q   <= wr_idx_q[ADDR_WIDTH-1:0];
                            data_q   <= bin_cnt;
                            wr_ptr_q <= wr_next;
                            wr_idx_q <= last_bin ? '0 : wr_next;
                            if (last_bin && !cont_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_addr         = addr_q;
    assign o_write_enable = we_q;
    assign o_data         = data_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_write_ptr    = wr_ptr_q;
    assign o_saturated    = sat_q;

endmodule

// File: tb/tb_counter_bin_writer.sv
// Randomised bench for counter_bin_writer: expected writes are derived from
// bin boundaries and summed event histories rather than from the RTL state.
module tb_counter_bin_writer;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int LW = 8;
    localparam int CNT_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          trigger;
    logic          continuous;
    logic [LW-1:0] bin_length;
    logic [AW:0]   num_bins;
    logic          event_i;
    logic [AW-1:0] o_addr;
    logic          o_write_enable;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic          o_done;
    logic [AW:0]   o_write_ptr;
    logic          o_saturated;

    int n_tests = 0;
    int n_fail  = 0;
    bit ev [0:2047];

    always #5 clk = ~clk;

    counter_bin_writer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_trigger     (trigger),
        .i_continuous  (continuous),
        .i_bin_length  (bin_length),
        .i_num_bins    (num_bins),
        .i_event       (event_i),
        .o_addr        (o_addr),
        .o_write_enable(o_write_enable),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_write_ptr   (o_write_ptr),
        .o_saturated   (o_saturated)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random with density pct, 1: all ones, 2: odd cycles only, 3: all zero
    task automatic fill_ev(input int mode, input int pct);
        for (int r = 0; r < 2048; r++) begin
            case (mode)
                0:       ev[r] = ($urandom_range(0, 99) < pct);
                1:       ev[r] = 1'b1;
                2:       ev[r] = r[0];
                default: ev[r] = 1'b0;
            endcase
        end
    endtask

    // Trigger at cycle T, then drive ev[r] in cycle T+r; A>0 drops enable from cycle T+A.
    task automatic scenario(input int L, input int N, input bit cont, input int A, input bit noisy);
        int Le, R, c, m, k, sum, nw, lastk;
        bit exp_we, exp_sat;
        Le = (L == 0) ? 1 : L;
        R  = (A > 0) ? A + 2 : N * Le + 2;
        k  = 0;
        enable     = 1'b1;
        trigger    = 1'b1;
        bin_length = LW'(L);
        num_bins   = (AW+1)'(N);
        continuous = cont;
        event_i    = 1'($urandom_range(0, 1));
        step();
        check("busy_start", 32'(o_busy), 32'd1);
        check("sat_clear", 32'(o_saturated), 32'd0);
        check("we_start", 32'(o_write_enable), 32'd0);
        nw = 0;
        lastk = -1;
        for (int r = 1; r <= R; r++) begin
            trigger = 1'b0;
            event_i = ev[r];
            enable  = !(A > 0 && r >= A);
            if (noisy && (cont || r < N * Le) && (A == 0 || r < A)) begin
                bin_length = LW'($urandom_range(0, 30));
                num_bins   = (AW+1)'($urandom_range(1, 16));
                continuous = 1'($urandom_range(0, 1));
                trigger    = 1'($urandom_range(0, 1));
            end
            step();
            c = r + 1;
            m = r;
            exp_we = 1'b0;
            if (m >= Le && (m % Le) == 0) begin
                k = m / Le - 1;
                if ((cont || k < N) && (A == 0 || m < A)) exp_we = 1'b1;
            end
            check("we", 32'(o_write_enable), 32'(exp_we));
            check("busy", 32'(o_busy), 32'((A == 0 || c <= A) && (cont || c <= N * Le)));
            check("done", 32'(o_done), 32'(exp_we && !cont && k == N - 1));
            if (exp_we) begin
                sum = 0;
                for (int j = k * Le + 1; j <= (k + 1) * Le; j++) sum += int'(ev[j]);
                check("addr", 32'(o_addr), k % N);
                check("data", 32'(o_data), (sum > CNT_MAX) ? CNT_MAX : sum);
                check("wptr", 32'(o_write_ptr), k % N + 1);
                nw++;
                lastk = k;
            end
        end
        exp_sat = 1'b0;
        for (int b = 0; b * Le + 1 <= R; b++) begin
            if (!cont && b >= N) break;
            sum = 0;
            for (int j = b * Le + 1; j <= (b + 1) * Le; j++) begin
                if (j <= R && (A == 0 || j < A)) sum += int'(ev[j]);
            end
            if (sum > CNT_MAX) exp_sat = 1'b1;
        end
        check("sat_end", 32'(o_saturated), 32'(exp_sat));
        check("wptr_end", 32'(o_write_ptr), (nw == 0) ? 0 : (lastk % N + 1));
        enable  = 1'b0;
        trigger = 1'b0;
        step();
        enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        trigger = 1'b0;
        continuous = 1'b0;
        bin_length = '0;
        num_bins = '0;
        event_i = 1'b0;
        step();
        step();
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_we", 32'(o_write_enable), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_wptr", 32'(o_write_ptr), 32'd0);
        check("rst_sat", 32'(o_saturated), 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        step();

        fill_ev(1, 0);  scenario(4, 3, 1'b0, 0, 1'b0);
        fill_ev(1, 0);  scenario(4, 3, 1'b0, 0, 1'b1);
        fill_ev(2, 0);  scenario(2, 2, 1'b1, 13, 1'b0);
        fill_ev(1, 0);  scenario(20, 1, 1'b0, 0, 1'b0);
        fill_ev(0, 50); scenario(3, 2, 1'b0, 0, 1'b0);
        fill_ev(1, 0);  scenario(4, 4, 1'b0, 10, 1'b0);
        fill_ev(1, 0);  scenario(3, 4, 1'b0, 6, 1'b0);
        fill_ev(0, 60); scenario(0, 3, 1'b0, 0, 1'b0);
        fill_ev(0, 70); scenario(1, 16, 1'b1, 40, 1'b0);
        fill_ev(3, 0);  ev[3] = 1'b1; ev[4] = 1'b1;
        scenario(3, 2, 1'b0, 0, 1'b0);

        enable = 1'b1;
        trigger = 1'b1;
        num_bins = '0;
        bin_length = LW'(1);
        event_i = 1'b1;
        step();
        check("n0_busy", 32'(o_busy), 32'd0);
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("n0_we", 32'(o_write_enable), 32'd0);
        end

        for (int it = 0; it < 24; it++) begin
            int L, N, A;
            bit cont;
            cont = 1'($urandom_range(0, 1));
            L = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 22) : $urandom_range(0, 6);
            N = $urandom_range(1, 16);
            if (cont) A = $urandom_range(1, 3 * N * ((L == 0) ? 1 : L) + 2);
            else if ($urandom_range(0, 1) == 1) A = $urandom_range(1, N * ((L == 0) ? 1 : L) + 1);
            else A = 0;
            if (A > 1000) A = 1000;
            fill_ev(0, $urandom_range(10, 100));
            scenario(L, N, cont, A, 1'($urandom_range(0, 1)));
        end

        enable = 1'b1;
        trigger = 1'b1;
        bin_length = LW'(3);
        num_bins = (AW+1)'(4);
        continuous = 1'b0;
        event_i = 1'b1;
        step();
        trigger = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        #1;
        check("mrst_addr", 32'(o_addr), 32'd0);
        check("mrst_we", 32'(o_write_enable), 32'd0);
        check("mrst_data", 32'(o_data), 32'd0);
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_done", 32'(o_done), 32'd0);
        check("mrst_wptr", 32'(o_write_ptr), 32'd0);
        check("mrst_sat", 32'(o_saturated), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("mrst_idle", 32'(o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_bin_writer.md
# counter_bin_writer

Time-binning front end of the counter: counts single-cycle event strobes over consecutive fixed-length bins and writes each finished bin count into the counter SRAM through its write-priority channel A. It sits directly upstream of the dual-channel counter SRAM; channel B stays free for bus readout. It supports single-shot acquisition of N bins and continuous ring-buffer acquisition.

## Interface
- ADDR_WIDTH, 12: SRAM address width.
- DATA_WIDTH, 18: SRAM word width and bin counter width.
- LEN_WIDTH, 32: width of the bin-length setting.
- i_clk  in  1: clock; all logic on the rising edge.
- i_rst  in  1: asynchronous, active-high reset.
- i_enable  in  1: level; low aborts any acquisition.
- i_trigger  in  1: single-cycle start strobe.
- i_continuous  in  1: 1 = ring-buffer mode, 0 = single shot.
- i_bin_length  in  LEN_WIDTH: clock cycles per bin; 0 is treated as 1.
- i_num_bins  in  ADDR_WIDTH+1: bins per shot, or ring size; range 1..2^ADDR_WIDTH.
- i_event  in  1: synchronous event strobe; one count per high cycle.
- o_addr  out  ADDR_WIDTH: SRAM channel A address.
- o_write_enable  out  1: SRAM channel A write strobe.
- o_data  out  DATA_WIDTH: SRAM channel A write data.
- o_busy  out  1: high while in RUN.
- o_done  out  1: one-cycle pulse at the end of a single shot.
- o_write_ptr  out  ADDR_WIDTH+1: number of bins written in the current pass.
- o_saturated  out  1: sticky; set when any bin saturated.

## Operation
- States:
  - IDLE: enter on reset.
  - RUN: IDLE -> RUN on i_trigger && i_enable && i_num_bins != 0.
  - Any state -> IDLE when i_enable is low. This is an abort: the partial bin is discarded, no write occurs, and o_done stays low.
- i_bin_length, i_num_bins and i_continuous are latched at trigger. Later changes are ignored until the next trigger. i_trigger in RUN is ignored.
- Bin counter: cleared at trigger. It increments when i_event is high. It saturates at 2^DATA_WIDTH-1 and sets o_saturated. o_saturated is cleared only by reset or an accepted trigger.
- Bin end: after the latched length of cycles in RUN, the count (including an event in the last cycle) is registered for writing. The counter restarts at 0, or at 1 if i_event is high in the first cycle of the next bin. There are no dead cycles between bins.
- Address: starts at 0 and increments after each write.
  - Single shot: after write number i_num_bins, go to IDLE and pulse o_done with the final write.
  - Continuous: the address wraps from i_num_bins-1 to 0, o_write_ptr returns to 0, and acquisition continues until i_enable is low.
- o_write_ptr counts completed writes. It is cleared on trigger and at each continuous wrap.

## Timing
- Reset values: o_addr=0, o_write_enable=0, o_data=0, o_busy=0, o_done=0, o_write_ptr=0, o_saturated=0; state IDLE.
- All outputs are registered.
- Trigger accepted in cycle T, latched length L:
  - o_busy is high from T+1.
  - Bin k covers cycles T+1+kL .. T+(k+1)L.
  - Its write is o_write_enable=1 for exactly one cycle, T+(k+1)L+1, with o_addr=k mod N and o_data=count.
  - o_write_ptr updates in the same cycle as its write.
- Single shot, N bins: o_done pulses in cycle T+NL+1 together with the last write. o_busy falls in that same cycle.
- L=1: one write per cycle, back to back.
- Abort during the cycle in which a bin ends: that bin's write is suppressed.

## Structure
- Shared package `counter_pkg`: the state enum (IDLE, RUN) and a saturating-increment function that is parameterised by width.
- Natural sub-module: `counter_bin_timer`, a cycle down-counter that is loaded with max(L,1) and emits a one-cycle bin_end strobe.
- The address, write-pointer and output registers stay in the top module.

## Test plan
- Single shot: L=4, N=3, events every cycle -> three writes of 4 to addresses 0,1,2 at T+5, T+9, T+13; o_done at T+13; o_write_ptr=3.
- Continuous: L=2, N=2, events on alternate cycles, run 6 bins -> addresses 0,1,0,1,0,1, each with data 1; o_write_ptr sequence 1,2,1,2,1,2; o_done never high.
- Saturation: DATA_WIDTH=4, L=20, events every cycle -> data 15; o_saturated=1; the next trigger clears it.
- Abort: disable at mid-bin 2 of N=4 -> exactly 2 writes, then IDLE; o_busy=0; no o_done. Asserting i_rst mid-run immediately gives all reset values.
- Edge cases:
  - L=0 behaves as L=1.
  - N=0 trigger is ignored.
  - A trigger during RUN has no effect.
  - An event in a bin's last cycle is counted in that bin.
  - An event in the next bin's first cycle is counted in the next bin.
